text_line_drawer: RTL and testbench

Upstream sequencer for symbol_drawer. It renders one line of text from a small symbol buffer by issuing one symbol_drawer job per character. Each job carries the pixel position and the cursor flags. The block advances the pen 15 pixels per symbol and clips symbols that do not fit on screen. It sits between the text/editor logic and symbol_drawer, which writes the framebuffer.

---
 rtl/text_line_drawer_if.sv | 39 +++
 rtl/text_line_drawer.sv | 201 ++++++++++++++++++++
 tb/tb_text_line_drawer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_line_drawer_if.sv
`default_nettype none
// ============================================================================
// Module      : text_line_drawer_if
// Description : Job bus between text_line_drawer (master) and symbol_drawer
//               (slave). One job = pixel position, symbol code and cursor
//               flags, handed over with a start/ready handshake. The master
//               keeps the job fields stable for the whole job.
// Signals     : sd_start        master->slave  one-cycle job launch
//               sd_ready        slave->master  drawer idle
//               sd_x, sd_y      master->slave  top-left pixel of the cell
//               sd_symbol       master->slave  symbol code
//               sd_cursor_left  master->slave  caret on the cell's left edge
//               sd_cursor_right master->slave  caret on the cell's right edge
// Revision    : 1.0 - initial release
// ============================================================================
interface text_line_drawer_if #(
    parameter int X_WIDTH      = 10,
    parameter int Y_WIDTH      = 9,
    parameter int SYMBOL_WIDTH = 7
);
    logic                    sd_start;
    logic                    sd_ready;
    logic [X_WIDTH-1:0]      sd_x;
    logic [Y_WIDTH-1:0]      sd_y;
    logic [SYMBOL_WIDTH-1:0] sd_symbol;
    logic                    sd_cursor_left;
    logic                    sd_cursor_right;

    modport master (
        output sd_start, sd_x, sd_y, sd_symbol, sd_cursor_left, sd_cursor_right,
        input  sd_ready
    );

    modport slave (
        input  sd_start, sd_x, sd_y, sd_symbol, sd_cursor_left, sd_cursor_right,
        output sd_ready
    );
endinterface
`default_nettype wire

// File: rtl/text_line_drawer.sv
`default_nettype none
// ============================================================================
// Module      : text_line_drawer
// Description : Renders one line of text from a small symbol buffer by
//               issuing one symbol_drawer job per character. The pen moves
//               15 pixels right per symbol; a symbol whose 15x20 cell does
//               not fit on screen ends the line and raises o_clipped.
//               Optional macro TEXT_LINE_DRAWER_WRAP_EN: a symbol that runs
//               off the right edge wraps to x=0 of the next row instead;
//               only the bottom edge then clips.
// Ports       : clk, rst_n        clock, asynchronous active-low reset
//               i_start/o_ready   line request handshake
//               o_done            one-cycle pulse at end of line
//               o_clipped         last line stopped at a screen edge
//               i_origin_x/_y     pixel position of the first symbol
//               i_length          symbols to draw (clamped to MAX_LENGTH)
//               i_cursor_en/_pos  caret enable / caret index
//               o_text_addr       text buffer read address
//               i_text_data       text buffer data (1-cycle sync read)
//               sd                job bus to symbol_drawer (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module text_line_drawer #(
    parameter  int SYMBOL_WIDTH      = 7,
    parameter  int HOR_ACTIVE_PIXELS = 640,
    parameter  int VER_ACTIVE_PIXELS = 480,
    parameter  int MAX_LENGTH        = 32,
    localparam int X_WIDTH           = $clog2(HOR_ACTIVE_PIXELS),
    localparam int Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS),
    localparam int LEN_WIDTH         = $clog2(MAX_LENGTH + 1),
    localparam int ADDR_WIDTH        = $clog2(MAX_LENGTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    output logic                    o_ready,
    output logic                    o_done,
    output logic                    o_clipped,
    input  logic [X_WIDTH-1:0]      i_origin_x,
    input  logic [Y_WIDTH-1:0]      i_origin_y,
    input  logic [LEN_WIDTH-1:0]    i_length,
    input  logic                    i_cursor_en,
    input  logic [LEN_WIDTH-1:0]    i_cursor_pos,
    output logic [ADDR_WIDTH-1:0]   o_text_addr,
    input  logic [SYMBOL_WIDTH-1:0] i_text_data,
    text_line_drawer_if.master      sd
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FETCH = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_ISSUE = 3'd3;
    localparam logic [2:0] c_DRAW  = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;

    localparam logic [LEN_WIDTH-1:0] c_max_len   = LEN_WIDTH'(MAX_LENGTH);
    localparam logic [LEN_WIDTH-1:0] c_len_one   = LEN_WIDTH'(1);
    localparam logic [X_WIDTH:0]     c_cell_w    = (X_WIDTH+1)'(15);
    localparam logic [X_WIDTH+1:0]   c_cell_w_ex = (X_WIDTH+2)'(15);
    localparam logic [X_WIDTH+1:0]   c_hor_limit = (X_WIDTH+2)'(HOR_ACTIVE_PIXELS);
    localparam logic [Y_WIDTH+1:0]   c_cell_h    = (Y_WIDTH+2)'(20);
    localparam logic [Y_WIDTH+1:0]   c_ver_limit = (Y_WIDTH+2)'(VER_ACTIVE_PIXELS);

    logic [2:0]              r_state;
    logic [LEN_WIDTH-1:0]    r_len;
    logic                    r_cursor_en;
    logic [LEN_WIDTH-1:0]    r_cursor_pos;
    logic [LEN_WIDTH-1:0]    r_idx;
    logic [X_WIDTH:0]        r_cur_x;
    logic [Y_WIDTH:0]        r_cur_y;
    logic                    r_clipped;
    logic                    r_draw_first;
    logic [X_WIDTH-1:0]      r_sd_x;
    logic [Y_WIDTH-1:0]      r_sd_y;
    logic [SYMBOL_WIDTH-1:0] r_sd_symbol;
    logic                    r_sd_cursor_left;
    logic                    r_sd_cursor_right;

    logic [LEN_WIDTH-1:0]    w_len_clamped;
    logic [LEN_WIDTH-1:0]    w_idx_next;
    logic                    w_x_fail;
    logic [Y_WIDTH+1:0]      w_y_base;
    logic [X_WIDTH:0]        w_x_eff;
    logic [Y_WIDTH+1:0]      w_y_eff;
    logic                    w_y_fail;
    logic                    w_clip;

    assign w_len_clamped = (i_length > c_max_len) ? c_max_len : i_length;
    assign w_idx_next    = r_idx + c_len_one;

    // Pen tests are done one bit wider than the pen so the sums never wrap.
    assign w_x_fail = ({1'b0, r_cur_x} + c_cell_w_ex) > c_hor_limit;
    assign w_y_base = {1'b0, r_cur_y};

`ifdef TEXT_LINE_DRAWER_WRAP_EN
    // A cell hanging off the right edge moves to the start of the next row;
    // the bottom-edge test is applied to that relocated position.
    assign w_x_eff = w_x_fail ? '0 : r_cur_x;
    assign w_y_eff = w_x_fail ? (w_y_base + c_cell_h) : w_y_base;
    assign w_clip  = w_y_fail;
`else
    assign w_x_eff = r_cur_x;
    assign w_y_eff = w_y_base;
    assign w_clip  = w_x_fail | w_y_fail;
`endif

    assign w_y_fail = (w_y_eff + c_cell_h) > c_ver_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= c_IDLE;
            r_len             <= '0;
            r_cursor_en       <= 1'b0;
            r_cursor_pos      <= '0;
            r_idx             <= '0;
            r_cur_x           <= '0;
            r_cur_y           <= '0;
            r_clipped         <= 1'b0;
            r_draw_first      <= 1'b0;
            r_sd_x            <= '0;
            r_sd_y            <= '0;
            r_sd_symbol       <= '0;
            r_sd_cursor_left  <= 1'b0;
            r_sd_cursor_right <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (i_start) begin
                        r_len        <= w_len_clamped;
                        r_cursor_en  <= i_cursor_en;
                        r_cursor_pos <= i_cursor_pos;
                        r_idx        <= '0;
                        r_cur_x      <= {1'b0, i_origin_x};
                        r_cur_y      <= {1'b0, i_origin_y};
                        r_clipped    <= 1'b0;
                        r_state      <= c_FETCH;
                    end
                end
                c_FETCH: begin
                    // The read address already equals idx, so the buffer
                    // samples it at the end of this cycle.
                    if (r_idx == r_len) begin
                        r_state <= c_DONE;
                    end else if (w_clip) begin
                        r_clipped <= 1'b1;
                        r_state   <= c_DONE;
                    end else begin
                        r_cur_x <= w_x_eff;
                        r_cur_y <= w_y_eff[Y_WIDTH:0];
                        r_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    // Job fields are frozen here and stay put until DRAW exits.
                    r_sd_symbol       <= i_text_data;
                    r_sd_x            <= r_cur_x[X_WIDTH-1:0];
                    r_sd_y            <= r_cur_y[Y_WIDTH-1:0];
                    r_sd_cursor_left  <= r_cursor_en & (r_idx == r_cursor_pos);
                    r_sd_cursor_right <= r_cursor_en & (w_idx_next == r_cursor_pos);
                    r_state           <= c_ISSUE;
                end
                c_ISSUE: begin
                    if (sd.sd_ready) begin
                        r_draw_first <= 1'b1;
                        r_state      <= c_DRAW;
                    end
                end
                c_DRAW: begin
                    // The drawer's ready is still high in the cycle right
                    // after the launch, so that cycle is not trusted.
                    r_draw_first <= 1'b0;
                    if (!r_draw_first && sd.sd_ready) begin
                        r_idx   <= w_idx_next;
                        r_cur_x <= r_cur_x + c_cell_w;
                        r_state <= c_FETCH;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign o_ready     = (r_state == c_IDLE);
    assign o_done      = (r_state == c_DONE);
    assign o_clipped   = r_clipped;
    assign o_text_addr = r_idx[ADDR_WIDTH-1:0];

    assign sd.sd_start        = (r_state == c_ISSUE) & sd.sd_ready;
    assign sd.sd_x            = r_sd_x;
    assign sd.sd_y            = r_sd_y;
    assign sd.sd_symbol       = r_sd_symbol;
    assign sd.sd_cursor_left  = r_sd_cursor_left;
    assign sd.sd_cursor_right = r_sd_cursor_right;

endmodule
`default_nettype wire

// File: tb/tb_text_line_drawer.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_line_drawer
// Description : Self-checking bench for text_line_drawer. A line-level model
//               lists the jobs each line must produce; one compare process
//               checks every sd_start, job-field stability, done, clipped
//               and line latency against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_line_drawer;

    localparam int SW = 7;
    localparam int H  = 640;
    localparam int V  = 480;
    localparam int ML = 32;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int LW = 6;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic          ready;
    logic          done;
    logic          clipped;
    logic [XW-1:0] origin_x;
    logic [YW-1:0] origin_y;
    logic [LW-1:0] length;
    logic          cursor_en;
    logic [LW-1:0] cursor_pos;
    logic [AW-1:0] text_addr;
    logic [SW-1:0] text_data;

    text_line_drawer_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .SYMBOL_WIDTH(SW)) sd_if ();

    text_line_drawer #(
        .SYMBOL_WIDTH(SW), .HOR_ACTIVE_PIXELS(H),
        .VER_ACTIVE_PIXELS(V), .MAX_LENGTH(ML)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .o_ready(ready),
        .o_done(done), .o_clipped(clipped), .i_origin_x(origin_x),
        .i_origin_y(origin_y), .i_length(length), .i_cursor_en(cursor_en),
        .i_cursor_pos(cursor_pos), .o_text_addr(text_addr),
        .i_text_data(text_data), .sd(sd_if)
    );

    // Text buffer with one-cycle synchronous read.
    logic [SW-1:0] mem [ML];
    always @(posedge clk) text_data <= mem[text_addr];

    // symbol_drawer stand-in: busy for 300 cycles after each job launch.
    int   busy;
    logic hold;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)               busy <= 0;
        else if (sd_if.sd_start)  busy <= 300;
        else if (busy > 0)        busy <= busy - 1;
    end
    assign sd_if.sd_ready = (busy == 0) && !hold;

    typedef struct { int x; int y; int sym; int cl; int cr; } job_t;
    job_t exp_q[$];
    job_t cur;
    int   n_vec = 0, n_err = 0;
    int   cyc = 0, start_cyc = 0, exp_lat = -1;
    bit   in_line = 0, exp_clip = 0, job_live = 0, ready_due = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic note_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event seen, none expected (t=%0t)", name, $time);
    endtask

    // Line-level model: walk the characters, place each cell, stop at edges.
    task automatic build_model(input int ox, input int oy, input int len,
                               input int cen, input int cpos);
        int   l, x, y;
        job_t j;
        exp_q.delete();
        exp_clip = 0;
        l = (len > ML) ? ML : len;
        x = ox;
        y = oy;
        for (int i = 0; i < l; i++) begin
            if (x + 15 > H) begin
`ifdef TEXT_LINE_DRAWER_WRAP_EN
                x = 0;
                y = y + 20;
`else
                exp_clip = 1;
                break;
`endif
            end
            if (y + 20 > V) begin
                exp_clip = 1;
                break;
            end
            j.x   = x;
            j.y   = y;
            j.sym = int'(mem[i]);
            j.cl  = (cen != 0 && i == cpos) ? 1 : 0;
            j.cr  = (cen != 0 && i + 1 == cpos) ? 1 : 0;
            exp_q.push_back(j);
            x = x + 15;
        end
        exp_lat = 2 + 304 * exp_q.size();
    endtask

    task automatic launch(input int ox, input int oy, input int len,
                          input int cen, input int cpos, input bit timed);
        int t = 0;
        while (!ready && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        if (!ready) note_fail("launch_ready_timeout");
        build_model(ox, oy, len, cen, cpos);
        if (!timed) exp_lat = -1;
        origin_x   = XW'(ox);
        origin_y   = YW'(oy);
        length     = LW'(len);
        cursor_en  = cen[0];
        cursor_pos = LW'(cpos);
        in_line    = 1;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (in_line && t < 20000) begin
            @(posedge clk); #1;
            t++;
        end
        if (in_line) begin
            note_fail("done_timeout");
            in_line = 0;
        end
        @(posedge clk); #1;
    endtask

    // Single compare process, sampling on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (ready_due) begin
                chk("ready_after_done", ready, 1);
                ready_due = 0;
            end
            if (start && ready && in_line) start_cyc = cyc;
            if (sd_if.sd_start) begin
                chk("sd_start_needs_ready", sd_if.sd_ready, 1);
                if (exp_q.size() == 0) begin
                    note_fail("unexpected_sd_start");
                end else begin
                    cur = exp_q.pop_front();
                    job_live = 1;
                    chk("job_x", sd_if.sd_x, cur.x);
                    chk("job_y", sd_if.sd_y, cur.y);
                    chk("job_symbol", sd_if.sd_symbol, cur.sym);
                    chk("job_cursor_left", sd_if.sd_cursor_left, cur.cl);
                    chk("job_cursor_right", sd_if.sd_cursor_right, cur.cr);
                end
            end else if (job_live && busy > 0) begin
                chk("hold_x", sd_if.sd_x, cur.x);
                chk("hold_y", sd_if.sd_y, cur.y);
                chk("hold_symbol", sd_if.sd_symbol, cur.sym);
                chk("hold_cursor_left", sd_if.sd_cursor_left, cur.cl);
                chk("hold_cursor_right", sd_if.sd_cursor_right, cur.cr);
            end
            if (done) begin
                if (!in_line) begin
                    note_fail("unexpected_done");
                end else begin
                    chk("jobs_left_at_done", exp_q.size(), 0);
                    chk("clipped_at_done", clipped, exp_clip);
                    if (exp_lat >= 0) chk("done_latency", cyc - start_cyc, exp_lat);
                    in_line = 0;
                end
                job_live  = 0;
                ready_due = 1;
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; hold = 1'b0;
        origin_x = '0; origin_y = '0; length = '0;
        cursor_en = 1'b0; cursor_pos = '0;
        for (int i = 0; i < ML; i++) mem[i] = SW'(i + 5);

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_clipped", clipped, 0);
        chk("rst_sd_start", sd_if.sd_start, 0);
        chk("rst_sd_x", sd_if.sd_x, 0);
        chk("rst_sd_y", sd_if.sd_y, 0);
        chk("rst_sd_symbol", sd_if.sd_symbol, 0);
        chk("rst_cursor_left", sd_if.sd_cursor_left, 0);
        chk("rst_cursor_right", sd_if.sd_cursor_right, 0);
        chk("rst_text_addr", text_addr, 0);
        @(posedge clk); #1;

        // Three symbols with caret before symbol 1
        launch(10, 40, 3, 1, 1, 1);
        chk("model_j0_x", exp_q[0].x, 10);
        chk("model_j0_sym", exp_q[0].sym, 5);
        chk("model_j0_cr", exp_q[0].cr, 1);
        chk("model_j1_x", exp_q[1].x, 25);
        chk("model_j1_cl", exp_q[1].cl, 1);
        chk("model_j2_x", exp_q[2].x, 40);
        chk("model_j2_sym", exp_q[2].sym, 7);
        chk("model_latency", exp_lat, 914);
        wait_done();

        // Right-edge clip: only x=610 and x=625 fit
        launch(610, 100, 4, 0, 0, 1);
        chk("model_clip_jobs", exp_q.size(), 2);
        chk("model_clip_flag", exp_clip, 1);
        wait_done();
        repeat (5) @(posedge clk);
        #1 chk("clipped_held", clipped, 1);

        // Empty line, also clears clipped
        launch(50, 50, 0, 0, 0, 1);
        chk("model_empty_latency", exp_lat, 2);
        wait_done();

        // Exact fit at both edges, caret at right edge of last symbol
        launch(625, 460, 1, 1, 1, 1);
        chk("model_fit_cr", exp_q[0].cr, 1);
        wait_done();

        // Bottom-edge clip with nothing drawn
        launch(0, 470, 2, 0, 0, 1);
        chk("model_vclip_jobs", exp_q.size(), 0);
        wait_done();

        // Drawer busy: stall in ISSUE until ready rises
        hold = 1'b1;
        launch(200, 200, 2, 1, 0, 0);
        repeat (48) begin
            @(posedge clk); #1;
            chk("no_sd_start_while_busy", sd_if.sd_start, 0);
        end
        @(posedge clk); #1;
        hold = 1'b0;
        #1 chk("sd_start_when_ready", sd_if.sd_start, 1);
        wait_done();

        // Start ignored mid-line, then reset mid-DRAW
        launch(100, 100, 3, 0, 0, 1);
        for (int t = 0; t < 2000 && exp_q.size() > 1; t++) begin
            @(posedge clk); #1;
        end
        repeat (20) @(posedge clk);
        #1 origin_x = '0; origin_y = '0; start = 1'b1;
        #1 chk("ready_low_in_draw", ready, 0);
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        in_line = 0; job_live = 0; exp_q.delete();
        @(negedge clk);
        chk("midrst_ready", ready, 1);
        chk("midrst_sd_start", sd_if.sd_start, 0);
        chk("midrst_done", done, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        launch(100, 100, 3, 0, 0, 1);
        chk("model_restart_sym0", exp_q[0].sym, 5);
        wait_done();

        // Over-long line clamps to 32 symbols; caret after the last one
        launch(0, 0, 40, 1, 32, 1);
        chk("model_clamp_jobs", exp_q.size(), 32);
        chk("model_clamp_last_x", exp_q[31].x, 465);
        chk("model_clamp_last_cr", exp_q[31].cr, 1);
        wait_done();

        // Caret at position 0
        launch(0, 0, 2, 1, 0, 1);
        chk("model_cpos0_cl", exp_q[0].cl, 1);
        wait_done();

        // Right-edge behaviour near the wrap point
        launch(600, 0, 3, 0, 0, 1);
`ifdef TEXT_LINE_DRAWER_WRAP_EN
        chk("model_wrap_jobs", exp_q.size(), 3);
        chk("model_wrap_x", exp_q[2].x, 0);
        chk("model_wrap_y", exp_q[2].y, 20);
        chk("model_wrap_clip", exp_clip, 0);
`else
        chk("model_nowrap_jobs", exp_q.size(), 2);
        chk("model_nowrap_clip", exp_clip, 1);
`endif
        wait_done();

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
